// File: rtl/data_memory_latency_pkg.sv
// Shared types and defaults for the latency-modelled MEM-stage data memory.
// FSM state encoding is fixed at 2 bits so it matches the pipeline's debug view.
package data_memory_latency_pkg;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_DONE = 2'd2
  } dm_state_t;

  localparam int BYTE_W       = 8;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DEPTH    = 64;
  localparam int DEF_BASE     = 1024;
  localparam int DEF_LATENCY  = 4;

endpackage

// File: rtl/data_memory_latency_array.sv
// DEPTH x DATA_W word storage: combinational read by index, byte-enable synchronous write.
// Contents are deliberately not reset.
module data_memory_latency_array
  import data_memory_latency_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [DATA_W/BYTE_W-1:0] wr_be,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  assign rd_data = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W/BYTE_W; i++) begin
        if (wr_be[i]) mem[wr_idx][BYTE_W*i +: BYTE_W] <= wr_data[BYTE_W*i +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/data_memory_latency.sv
// MEM-stage data memory with fixed access latency behind a request/ready handshake.
// busy_out freezes the pipeline until the one-cycle ready_out pulse; out-of-range accesses flag addr_err_out.
module data_memory_latency
  import data_memory_latency_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int BASE_ADDR = DEF_BASE,
  parameter int LATENCY   = DEF_LATENCY
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_read_in,
  input  logic                     mem_write_in,
  input  logic [ADDR_W-1:0]        address_in,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [DATA_W/BYTE_W-1:0] byte_en_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     ready_out,
  output logic                     busy_out,
  output logic                     addr_err_out
);

  localparam int BYTES = DATA_W / BYTE_W;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

  // One extra bit so the window end never wraps at the top of the address space.
  localparam logic [ADDR_W:0] WIN_LO = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] WIN_HI = (ADDR_W+1)'(BASE_ADDR + DEPTH * BYTES);

  dm_state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              op_wr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BYTES-1:0]  be_q;
  logic              err_q;

  logic              req;
  logic [ADDR_W:0]   addr_ext;
  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  in_idx;
  logic              in_err;
  logic              unused_offset;
  logic              is_idle;
  logic              cur_wr;
  logic              cur_err;
  logic [IDX_W-1:0]  cur_idx;
  logic [DATA_W-1:0] rd_data;
  logic              done_d;
  logic              wr_en;

  assign req           = mem_read_in | mem_write_in;
  assign busy_out      = req & ~ready_out;
  assign addr_ext      = {1'b0, address_in};
  assign offset        = address_in - WIN_LO[ADDR_W-1:0];
  assign in_idx        = offset[OFF_W +: IDX_W];
  assign unused_offset = ^offset;
  assign in_err        = (addr_ext < WIN_LO) || (addr_ext >= WIN_HI);

  // With LATENCY==1 DONE is entered straight from IDLE, before the latches hold the request.
  assign is_idle = (state_q == DM_IDLE);
  assign cur_wr  = is_idle ? mem_write_in : op_wr_q;
  assign cur_err = is_idle ? in_err       : err_q;
  assign cur_idx = is_idle ? in_idx       : idx_q;

  assign done_d = (state_d == DM_DONE);
  assign wr_en  = (state_q == DM_DONE) && op_wr_q && !err_q && !rst;

  always_comb begin
    state_d = state_q;
    case (state_q)
      DM_IDLE: if (req) state_d = (LATENCY == 1) ? DM_DONE : DM_WAIT;
      DM_WAIT: if (cnt_q == CNT_W'(1)) state_d = DM_DONE;
      DM_DONE: state_d = DM_IDLE;
      default: state_d = DM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= DM_IDLE;
      cnt_q        <= '0;
      op_wr_q      <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      err_q        <= 1'b0;
      data_out     <= '0;
      ready_out    <= 1'b0;
      addr_err_out <= 1'b0;
    end else begin
      state_q <= state_d;
      if (is_idle && req) begin
        op_wr_q <= mem_write_in;
        idx_q   <= in_idx;
        wdata_q <= data_in;
        be_q    <= byte_en_in;
        err_q   <= in_err;
        cnt_q   <= CNT_W'(LATENCY - 1);
      end else if (state_q == DM_WAIT) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      ready_out    <= done_d;
      addr_err_out <= done_d & cur_err;
      if (done_d && !cur_wr) data_out <= cur_err ? '0 : rd_data;
    end
  end

  data_memory_latency_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .we      (wr_en),
    .wr_idx  (idx_q),
    .wr_data (wdata_q),
    .wr_be   (be_q),
    .rd_idx  (cur_idx),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_data_memory_latency.sv
// Directed bench for data_memory_latency: a LATENCY=4 instance and a LATENCY=1 instance.
module tb_data_memory_latency;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // LATENCY = 4 instance
  logic        rst4 = 1'b1, rd4 = 1'b0, wr4 = 1'b0;
  logic [31:0] addr4 = '0, din4 = '0, dout4;
  logic [3:0]  be4 = '0;
  logic        ready4, busy4, err4;

  // LATENCY = 1 instance
  logic        rst1 = 1'b1, rd1 = 1'b0, wr1 = 1'b0;
  logic [31:0] addr1 = '0, din1 = '0, dout1;
  logic [3:0]  be1 = '0;
  logic        ready1, busy1, err1;

  data_memory_latency #(.LATENCY(4)) u_dut4 (
    .clk(clk), .rst(rst4), .mem_read_in(rd4), .mem_write_in(wr4), .address_in(addr4),
    .data_in(din4), .byte_en_in(be4), .data_out(dout4), .ready_out(ready4),
    .busy_out(busy4), .addr_err_out(err4)
  );

  data_memory_latency #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst1), .mem_read_in(rd1), .mem_write_in(wr1), .address_in(addr1),
    .data_in(din1), .byte_en_in(be1), .data_out(dout1), .ready_out(ready1),
    .busy_out(busy1), .addr_err_out(err1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] r_dat;
  logic        r_err;
  int          r_lat;
  logic        r_busy;
  logic        saw_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts an access in the current cycle (called just after a negedge), waits for ready_out
  // with a bounded budget, then checks the pulse falls in the following cycle.
  // hold>0 drops the request after that many cycles; busy_ok tracks busy == request level.
  task automatic acc4(input logic wr, input logic rd, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [3:0] be, input int hold,
                      output logic [31:0] dat, output logic err, output int lat,
                      output logic busy_ok);
    wr4 = wr; rd4 = rd; addr4 = addr; din4 = wd; be4 = be;
    dat = '0; err = 1'b0; lat = 0;
    #1 busy_ok = busy4;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ready4) begin
        lat = i; dat = dout4; err = err4;
        if (busy4 !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy4 !== (wr4 | rd4)) busy_ok = 1'b0;
      if (i == hold) begin wr4 = 1'b0; rd4 = 1'b0; end
    end
    wr4 = 1'b0; rd4 = 1'b0;
    @(negedge clk);
    check("ready_pulse_end", {31'b0, ready4}, 32'd0);
  endtask

  initial begin
    // ---------------- reset ----------------
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, ready4}, 32'd0);
    check("rst_dout", dout4, 32'h0);
    check("rst_err", {31'b0, err4}, 32'd0);
    rst4 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'b0, busy4}, 32'd0);

    // ---------------- LATENCY = 4 ----------------
    acc4(1, 0, 32'd1024, 32'hDEADBEEF, 4'hF, 0, r_dat, r_err, r_lat, r_busy);
    check("wr1024_lat", r_lat, 32'd4);
    check("wr1024_busy", {31'b0, r_busy}, 32'd1);
    check("wr1024_err", {31'b0, r_err}, 32'd0);
    acc4(0, 1, 32'd1024, 32'h0, 4'h0, 0, r_dat, r_err, r_lat, r_busy);
    check("rd1024_lat", r_lat, 32'd4);
    check("rd1024_busy", {31'b0, r_busy}, 32'd1);
    check("rd1024_dat", r_dat, 32'hDEADBEEF);

    acc4(1, 0, 32'd1028, 32'h11223344, 4'hF, 0, r_dat, r_err, r_lat, r_busy);
    acc4(1, 0, 32'd1028, 32'h000000AA, 4'h1, 0, r_dat, r_err, r_lat, r_busy);
    acc4(0, 1, 32'd1028, 32'h0, 4'h0, 0, r_dat, r_err, r_lat, r_busy);
    check("byte_en_merge", r_dat, 32'h112233AA);

    acc4(0, 1, 32'd1020, 32'h0, 4'h0, 0, r_dat, r_err, r_lat, r_busy);
    check("rd_below_lat", r_lat, 32'd4);
    check("rd_below_err", {31'b0, r_err}, 32'd1);
    check("rd_below_dat", r_dat, 32'h0);
    acc4(0, 1, 32'd1280, 32'h0, 4'h0, 0, r_dat, r_err, r_lat, r_busy);
    check("rd_above_err", {31'b0, r_err}, 32'd1);
    check("rd_above_dat", r_dat, 32'h0);
    acc4(1, 0, 32'd1280, 32'hBADBAD00, 4'hF, 0, r_dat, r_err, r_lat, r_busy);
    check("wr_above_err", {31'b0, r_err}, 32'd1);
    acc4(0, 1, 32'd1024, 32'h0, 4'h0, 0, r_dat, r_err, r_lat, r_busy);
    check("after_err_dat", r_dat, 32'hDEADBEEF);
    check("after_err_flag", {31'b0, r_err}, 32'd0);

    // Last in-range word
    acc4(1, 0, 32'd1276, 32'hCAFEF00D, 4'hF, 0, r_dat, r_err, r_lat, r_busy);
    acc4(0, 1, 32'd1276, 32'h0, 4'h0, 0, r_dat, r_err, r_lat, r_busy);
    check("last_word_dat", r_dat, 32'hCAFEF00D);
    check("last_word_err", {31'b0, r_err}, 32'd0);

    // Request dropped after one cycle still completes
    acc4(1, 0, 32'd1032, 32'h00000055, 4'hF, 1, r_dat, r_err, r_lat, r_busy);
    check("drop_lat", r_lat, 32'd4);
    acc4(0, 1, 32'd1032, 32'h0, 4'h0, 0, r_dat, r_err, r_lat, r_busy);
    check("drop_readback", r_dat, 32'h00000055);

    // Zero byte enables leave the word alone
    acc4(1, 0, 32'd1028, 32'hFFFFFFFF, 4'h0, 0, r_dat, r_err, r_lat, r_busy);
    check("be0_lat", r_lat, 32'd4);
    acc4(0, 1, 32'd1028, 32'h0, 4'h0, 0, r_dat, r_err, r_lat, r_busy);
    check("be0_readback", r_dat, 32'h112233AA);

    // Reset during WAIT abandons the pending write
    acc4(1, 0, 32'd1036, 32'h00000099, 4'hF, 0, r_dat, r_err, r_lat, r_busy);
    wr4 = 1'b1; addr4 = 32'd1036; din4 = 32'h00000077; be4 = 4'hF;
    @(negedge clk);
    wr4 = 1'b0;
    @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    check("rst_wait_ready", {31'b0, ready4}, 32'd0);
    rst4 = 1'b0;
    saw_ready = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready4) saw_ready = 1'b1;
    end
    check("rst_wait_no_pulse", {31'b0, saw_ready}, 32'd0);
    acc4(0, 1, 32'd1036, 32'h0, 4'h0, 0, r_dat, r_err, r_lat, r_busy);
    check("rst_wait_readback", r_dat, 32'h00000099);

    // ---------------- LATENCY = 1 ----------------
    wr1 = 1'b1; addr1 = 32'd1024; din1 = 32'hA5A5A5A5; be1 = 4'hF;
    @(negedge clk);
    check("l1_wr0_ready", {31'b0, ready1}, 32'd1);
    wr1 = 1'b0;
    @(negedge clk);
    wr1 = 1'b1; addr1 = 32'd1028; din1 = 32'h5A5A5A5A;
    @(negedge clk);
    check("l1_wr1_ready", {31'b0, ready1}, 32'd1);
    wr1 = 1'b0;
    @(negedge clk);

    rd1 = 1'b1; addr1 = 32'd1024;
    @(negedge clk);
    check("l1_rd0_ready", {31'b0, ready1}, 32'd1);
    check("l1_rd0_dat", dout1, 32'hA5A5A5A5);
    addr1 = 32'd1028;
    @(negedge clk);
    check("l1_gap_ready", {31'b0, ready1}, 32'd0);
    check("l1_gap_busy", {31'b0, busy1}, 32'd1);
    @(negedge clk);
    check("l1_rd1_ready", {31'b0, ready1}, 32'd1);
    check("l1_rd1_dat", dout1, 32'h5A5A5A5A);
    rd1 = 1'b0;
    @(negedge clk);

    rd1 = 1'b1; wr1 = 1'b1; addr1 = 32'd1024; din1 = 32'h12345678; be1 = 4'hF;
    @(negedge clk);
    check("l1_both_ready", {31'b0, ready1}, 32'd1);
    check("l1_both_dout_held", dout1, 32'h5A5A5A5A);
    rd1 = 1'b0; wr1 = 1'b0;
    @(negedge clk);
    rd1 = 1'b1;
    @(negedge clk);
    check("l1_both_readback", dout1, 32'h12345678);
    rd1 = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
